cdma_lite_slave: RTL and testbench

- AXI4-Lite responder (slave) register file for the CDMA configuration space; terminates the AW/W/B write traffic our CDMA control master issues, plus an AR/R read path for status polling.
- Holds source address (0x18), destination address (0x20) and bytes-to-transfer (0x28) registers. Issues a one-cycle start pulse to the copy engine when BTT is written.
- Tracks busy/idle and completion status, and raises an interrupt.

---
 rtl/cdma_pkg.sv | 35 +++
 rtl/cdma_lite_wr_capture.sv | 76 +++++++
 rtl/cdma_lite_slave.sv | 157 +++++++++++++++
 tb/tb_cdma_lite_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_pkg.sv
package cdma_pkg;

  localparam logic [31:0] CDMA_CR  = 32'h0000_0000;
  localparam logic [31:0] CDMA_SR  = 32'h0000_0004;
  localparam logic [31:0] CDMA_SA  = 32'h0000_0018;
  localparam logic [31:0] CDMA_DA  = 32'h0000_0020;
  localparam logic [31:0] CDMA_BTT = 32'h0000_0028;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned SR_IDLE  = 1;
  localparam int unsigned SR_IOC   = 12;
  localparam int unsigned CR_IRQEN = 12;

  typedef enum logic [2:0] {
    REG_CR,
    REG_SR,
    REG_SA,
    REG_DA,
    REG_BTT,
    REG_NONE
  } cdma_reg_e;

  // Decodes a word index (byte address with the two LSBs dropped).
  function automatic cdma_reg_e decode_reg(input logic [29:0] widx);
    if (widx == CDMA_CR[31:2])  return REG_CR;
    if (widx == CDMA_SR[31:2])  return REG_SR;
    if (widx == CDMA_SA[31:2])  return REG_SA;
    if (widx == CDMA_DA[31:2])  return REG_DA;
    if (widx == CDMA_BTT[31:2]) return REG_BTT;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/cdma_lite_wr_capture.sv
// AW/W one-entry holding registers and B response channel.
module cdma_lite_wr_capture
  import cdma_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data,
  input  logic [1:0]        commit_resp
);

  logic              aw_held, w_held;
  logic              aw_held_nxt, w_held_nxt, bvalid_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              aw_hs, w_hs;

  // A handshake in flight counts as held, so commit lands on the handshake edge.
  always_comb begin
    aw_hs       = awvalid & awready;
    w_hs        = wvalid & wready;
    commit      = (aw_held | aw_hs) & (w_held | w_hs);
    commit_addr = aw_held ? addr_q : awaddr;
    commit_data = w_held ? data_q : wdata;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    bvalid_nxt  = bvalid;
    if (commit) begin
      aw_held_nxt = 1'b0;
      w_held_nxt  = 1'b0;
      bvalid_nxt  = 1'b1;
    end else begin
      if (aw_hs) aw_held_nxt = 1'b1;
      if (w_hs)  w_held_nxt  = 1'b1;
      if (bvalid && bready) bvalid_nxt = 1'b0;
    end
  end

  // Ready flags are registered from next state so they stay low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      awready <= 1'b0;
      wready  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      aw_held <= aw_held_nxt;
      w_held  <= w_held_nxt;
      bvalid  <= bvalid_nxt;
      awready <= !aw_held_nxt && !bvalid_nxt;
      wready  <= !w_held_nxt && !bvalid_nxt;
      if (aw_hs) addr_q <= awaddr;
      if (w_hs)  data_q <= wdata;
      if (commit) bresp <= commit_resp;
      else if (bvalid && bready) bresp <= RESP_OKAY;
    end
  end

endmodule

// File: rtl/cdma_lite_slave.sv
// CDMA AXI4-Lite configuration register slave.
module cdma_lite_slave
  import cdma_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BTT_W  = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] cfg_src_addr,
  output logic [DATA_W-1:0] cfg_dst_addr,
  output logic [BTT_W-1:0]  cfg_btt,
  output logic              xfer_start,
  input  logic              xfer_done,
  output logic              irq
);

  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [1:0]        commit_resp;
  cdma_reg_e         wr_reg, rd_reg;
  logic              wr_ok;
  logic [BTT_W-1:0]  btt_wdata;
  logic              busy, ioc, irq_en;
  logic [DATA_W-1:0] rd_val;
  logic [1:0]        rd_resp;
  logic              ar_hs, rvalid_nxt;
  logic              unused_lsbs;

  cdma_lite_wr_capture #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .commit     (commit),
    .commit_addr(commit_addr),
    .commit_data(commit_data),
    .commit_resp(commit_resp)
  );

  always_comb begin
    unused_lsbs = ^{commit_addr[1:0], araddr[1:0]};
    wr_reg      = decode_reg(30'(commit_addr[ADDR_W-1:2]));
    btt_wdata   = commit_data[BTT_W-1:0];
    commit_resp = RESP_OKAY;
    case (wr_reg)
      REG_SA, REG_DA, REG_BTT: if (busy) commit_resp = RESP_SLVERR;
      REG_NONE:                commit_resp = RESP_SLVERR;
      default:                 commit_resp = RESP_OKAY;
    endcase
    wr_ok = commit && (commit_resp == RESP_OKAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_src_addr <= '0;
      cfg_dst_addr <= '0;
      cfg_btt      <= '0;
      xfer_start   <= 1'b0;
      busy         <= 1'b0;
      ioc          <= 1'b0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
    end else begin
      xfer_start <= 1'b0;
      if (wr_ok) begin
        case (wr_reg)
          REG_CR: irq_en       <= commit_data[CR_IRQEN];
          REG_SA: cfg_src_addr <= commit_data;
          REG_DA: cfg_dst_addr <= commit_data;
          REG_BTT: begin
            cfg_btt <= btt_wdata;
            if (btt_wdata != '0) begin
              busy       <= 1'b1;
              xfer_start <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Completion set takes priority over a coincident W1C.
      if (xfer_done && busy) begin
        busy <= 1'b0;
        ioc  <= 1'b1;
      end else if (wr_ok && wr_reg == REG_SR && commit_data[SR_IOC]) begin
        ioc <= 1'b0;
      end
      irq <= ioc & irq_en;
    end
  end

  always_comb begin
    rd_reg  = decode_reg(30'(araddr[ADDR_W-1:2]));
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_reg)
      REG_CR: rd_val[CR_IRQEN] = irq_en;
      REG_SR: begin
        rd_val[SR_IDLE] = !busy;
        rd_val[SR_IOC]  = ioc;
      end
      REG_SA:  rd_val = cfg_src_addr;
      REG_DA:  rd_val = cfg_dst_addr;
      REG_BTT: rd_val[BTT_W-1:0] = cfg_btt;
      default: rd_resp = RESP_SLVERR;
    endcase
    ar_hs      = arvalid & arready;
    rvalid_nxt = rvalid;
    if (ar_hs) rvalid_nxt = 1'b1;
    else if (rvalid && rready) rvalid_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      arready <= 1'b0;
    end else begin
      rvalid  <= rvalid_nxt;
      arready <= !rvalid_nxt;
      if (ar_hs) begin
        rdata <= rd_val;
        rresp <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_cdma_lite_slave.sv
module tb_cdma_lite_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [9:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] cfg_src_addr, cfg_dst_addr;
  logic [25:0] cfg_btt;
  logic        xfer_start;
  logic        xfer_done = 1'b0;
  logic        irq;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  logic [31:0] m_sa = '0, m_da = '0;
  logic [25:0] m_btt = '0;
  bit          m_busy = 0, m_ioc = 0, m_irqen = 0, m_start = 0;
  logic        m_irq;

  cdma_lite_slave #(.ADDR_W(10), .DATA_W(32), .BTT_W(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr), .cfg_btt(cfg_btt),
    .xfer_start(xfer_start), .xfer_done(xfer_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // irq is the completion flag gated by enable, seen one clock later
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_irq <= 1'b0;
    else        m_irq <= m_ioc & m_irqen;

  // per-cycle check of the configuration/control outputs
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cfg_src_addr", cfg_src_addr, m_sa);
      chk("cfg_dst_addr", cfg_dst_addr, m_da);
      chk("cfg_btt", 32'(cfg_btt), 32'(m_btt));
      chkb("xfer_start", xfer_start, m_start);
      chkb("irq", irq, m_irq);
    end
  end

  task automatic model_reset();
    m_sa = '0; m_da = '0; m_btt = '0;
    m_busy = 0; m_ioc = 0; m_irqen = 0; m_start = 0;
  endtask

  task automatic model_write(input logic [9:0] a, input logic [31:0] d,
                             output logic [1:0] resp, output bit start);
    int unsigned off;
    off = {22'b0, a[9:2], 2'b00};
    resp = 2'b00;
    start = 0;
    case (off)
      'h00: m_irqen = d[12];
      'h04: if (d[12]) m_ioc = 0;
      'h18: if (m_busy) resp = 2'b10; else m_sa = d;
      'h20: if (m_busy) resp = 2'b10; else m_da = d;
      'h28: begin
        if (m_busy) resp = 2'b10;
        else begin
          m_btt = d[25:0];
          if (d[25:0] != 0) begin m_busy = 1; start = 1; end
        end
      end
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] r);
    int unsigned off;
    off = {22'b0, a[9:2], 2'b00};
    d = 0;
    r = 2'b00;
    case (off)
      'h00: d = m_irqen ? 32'h1000 : 32'h0;
      'h04: d = (m_busy ? 32'h0 : 32'h2) + (m_ioc ? 32'h1000 : 32'h0);
      'h18: d = m_sa;
      'h20: d = m_da;
      'h28: d = {6'b0, m_btt};
      default: r = 2'b10;
    endcase
  endtask

  // Drivers run at posedge+1; DUT outputs are stable until the next posedge.
  task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input int aw_dly,
                           input int w_dly, input int b_dly, input bit done_on_commit,
                           output logic [1:0] got);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, busy_before = 0, es;
    logic [1:0] er;
    got = 2'b11;
    while (!(aw_done && w_done) && cyc < 40) begin
      awaddr  = a;
      wdata   = d;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      chkb("awready_idle", awready, !aw_done);
      chkb("wready_idle", wready, !w_done);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      xfer_done = done_on_commit && (aw_done || aw_hs) && (w_done || w_hs);
      busy_before = m_busy;
      @(posedge clk); #1;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
      awvalid = 0; wvalid = 0; xfer_done = 0;
      if (!(aw_done && w_done)) chkb("bvalid_early", bvalid, 1'b0);
    end
    if (!(aw_done && w_done)) begin
      vectors++; errors++;
      $display("FAIL write_timeout: actual=no handshake required=AW+W accepted addr=%h", a);
      return;
    end
    chkb("b_latency", bvalid, 1'b1);
    model_write(a, d, er, es);
    if (done_on_commit && busy_before) begin m_busy = 0; m_ioc = 1; end
    m_start = es;
    chk("bresp", 32'(bresp), 32'(er));
    chkb("start_on_b", xfer_start, es);
    got = bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk); #1;
      m_start = 0;
      chkb("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", 32'(bresp), 32'(er));
      chkb("awready_bhold", awready, 1'b0);
      chkb("wready_bhold", wready, 1'b0);
    end
    bready = 1;
    @(posedge clk); #1;
    m_start = 0;
    bready = 0;
    chkb("bvalid_clear", bvalid, 1'b0);
    chkb("awready_after_b", awready, 1'b1);
    chkb("wready_after_b", wready, 1'b1);
  endtask

  task automatic axi_read(input logic [9:0] a, input int r_dly,
                          output logic [31:0] gd, output logic [1:0] gr);
    int cyc = 0;
    logic [31:0] ed;
    logic [1:0]  er;
    araddr  = a;
    arvalid = 1;
    while (!arready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!arready) begin
      vectors++; errors++;
      $display("FAIL read_timeout: actual=arready low required=arready high");
      arvalid = 0; gd = '0; gr = 2'b11;
      return;
    end
    model_read(a, ed, er);
    @(posedge clk); #1;
    arvalid = 0;
    chkb("rvalid", rvalid, 1'b1);
    chk("rdata", rdata, ed);
    chk("rresp", 32'(rresp), 32'(er));
    chkb("arready_busy", arready, 1'b0);
    gd = rdata;
    gr = rresp;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk); #1;
      chkb("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, ed);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chkb("rvalid_clear", rvalid, 1'b0);
    chkb("arready_after_r", arready, 1'b1);
  endtask

  task automatic pulse_done();
    bit bb;
    bb = m_busy;
    xfer_done = 1;
    @(posedge clk); #1;
    xfer_done = 0;
    if (bb) begin m_busy = 0; m_ioc = 1; end
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chkb("awready_out_of_reset", awready, 1'b1);
    chkb("wready_out_of_reset", wready, 1'b1);
    chkb("arready_out_of_reset", arready, 1'b1);
  endtask

  logic [9:0] addr_tab [7] = '{10'h000, 10'h004, 10'h018, 10'h020, 10'h028, 10'h03C, 10'h100};

  function automatic logic [9:0] pick_addr();
    int unsigned s;
    s = $urandom_range(0, 6);
    if (s == 6) return 10'($urandom_range(0, 1023));
    return addr_tab[s] | 10'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [9:0]  a;

    // reset state
    repeat (3) @(negedge clk);
    chkb("rst_awready", awready, 1'b0);
    chkb("rst_wready", wready, 1'b0);
    chkb("rst_bvalid", bvalid, 1'b0);
    chkb("rst_arready", arready, 1'b0);
    chkb("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp", {28'b0, bresp, rresp}, 32'h0);
    chk("rst_cfg", cfg_src_addr | cfg_dst_addr | 32'(cfg_btt), 32'h0);
    chkb("rst_start_irq", xfer_start | irq, 1'b0);
    release_reset();

    // master-style configure and launch
    axi_write(10'h018, 32'h1000_0000, 0, 0, 0, 0, r); chk("sa_okay", 32'(r), 32'h0);
    axi_write(10'h020, 32'h2000_0000, 0, 0, 0, 0, r); chk("da_okay", 32'(r), 32'h0);
    axi_write(10'h028, 32'h0000_0040, 0, 0, 0, 0, r); chk("btt_okay", 32'(r), 32'h0);
    chk("lit_sa", cfg_src_addr, 32'h1000_0000);
    chk("lit_da", cfg_dst_addr, 32'h2000_0000);
    chk("lit_btt", 32'(cfg_btt), 32'h40);
    axi_read(10'h004, 0, d, r); chk("lit_sr_busy", d, 32'h0);

    // errors while busy and on unmapped space
    axi_write(10'h018, 32'h5, 0, 0, 0, 0, r); chk("lit_sa_busy_slverr", 32'(r), 32'h2);
    chk("lit_sa_unchanged", cfg_src_addr, 32'h1000_0000);
    axi_write(10'h03C, 32'h1, 0, 0, 0, 0, r); chk("lit_unmapped_wr", 32'(r), 32'h2);
    axi_read(10'h03C, 2, d, r);
    chk("lit_unmapped_rdata", d, 32'h0);
    chk("lit_unmapped_rresp", 32'(r), 32'h2);
    pulse_done();

    // AW leads W by three cycles
    axi_write(10'h020, 32'hDEAD_BEEF, 0, 3, 0, 0, r);
    chk("lit_da_split", cfg_dst_addr, 32'hDEAD_BEEF);

    // B back-pressure, then interrupt and W1C
    axi_write(10'h000, 32'h0000_1000, 0, 0, 4, 0, r);
    axi_write(10'h028, 32'h0000_0010, 0, 0, 0, 0, r);
    pulse_done();
    @(posedge clk); #1;
    chkb("lit_irq_set", irq, 1'b1);
    axi_read(10'h004, 0, d, r); chk("lit_sr_done", d, 32'h0000_1002);
    axi_write(10'h004, 32'h0000_1000, 0, 0, 0, 0, r);
    chkb("lit_irq_clear", irq, 1'b0);
    axi_read(10'h004, 0, d, r); chk("lit_sr_cleared", d, 32'h0000_0002);

    // completion coincident with W1C: set wins
    axi_write(10'h028, 32'h0000_0020, 0, 0, 0, 0, r);
    axi_write(10'h004, 32'h0000_1000, 0, 0, 0, 1, r);
    axi_read(10'h004, 1, d, r); chk("lit_sr_set_wins", d, 32'h0000_1002);

    // zero BTT stores but does not launch
    axi_write(10'h028, 32'h0, 0, 0, 0, 0, r); chk("lit_btt0_okay", 32'(r), 32'h0);
    chk("lit_btt0", 32'(cfg_btt), 32'h0);
    axi_read(10'h004, 0, d, r); chk("lit_sr_idle_btt0", d, 32'h0000_1002);

    // randomized traffic against the model
    for (int n = 0; n < 120; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      a = pick_addr();
      if (op < 5) begin
        d = $urandom;
        if ($urandom_range(0, 3) == 0) d = 32'h0;
        axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, r);
      end else if (op < 8) begin
        axi_read(a, $urandom_range(0, 2), d, r);
      end else begin
        pulse_done();
      end
    end

    // reset while a write response is pending
    axi_write(10'h018, 32'hA5A5_0000, 0, 0, 0, 0, r);
    axi_write(10'h028, 32'h80, 0, 0, 0, 0, r);
    awaddr = 10'h018; wdata = 32'h5; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    chkb("lit_pending_bvalid", bvalid, 1'b1);
    chk("lit_pending_bresp", 32'(bresp), 32'h2);
    rst_n = 0;
    model_reset();
    #1;
    chkb("midrst_bvalid", bvalid, 1'b0);
    chk("midrst_cfg", cfg_src_addr | cfg_dst_addr | 32'(cfg_btt), 32'h0);
    chkb("midrst_awready", awready, 1'b0);
    release_reset();
    axi_read(10'h004, 0, d, r); chk("lit_sr_after_rst", d, 32'h0000_0002);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
